mem_port_arbiter: RTL and testbench

//  Shares one single-ported instruction/data memory between the CPU fetch stage (IF) and the load/store unit (D).

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/arb_grant_sel.sv | 38 +++
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } req_id_e;

  // Wide enough for any practical data width; users slice the low DATA_W/8 bits.
  localparam logic [63:0] BE_ALL = '1;

endpackage

// File: rtl/arb_grant_sel.sv
// Combinational grant select between fetch (IF) and load/store (D) requesters.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the grant is consumed.
// Config macro: MEM_ARB_RR_EN selects round-robin, otherwise fixed D > IF priority.
// Ports: if_req_i/d_req_i requests, last_i last granted requester,
//        any_o some request pending, grant_o chosen requester.
module arb_grant_sel
  import mem_arb_pkg::*;
(
  input  logic    if_req_i,
  input  logic    d_req_i,
  input  req_id_e last_i,
  output logic    any_o,
  output req_id_e grant_o
);

  assign any_o = if_req_i | d_req_i;

`ifdef MEM_ARB_RR_EN
  // On contention the requester that did not win last time goes next.
  always_comb begin
    grant_o = REQ_IF;
    if (if_req_i && d_req_i) begin
      grant_o = (last_i == REQ_D) ? REQ_IF : REQ_D;
    end else if (d_req_i) begin
      grant_o = REQ_D;
    end
  end
`else
  logic unused_last;
  assign unused_last = (last_i == REQ_D);

  always_comb begin
    grant_o = d_req_i ? REQ_D : REQ_IF;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between CPU fetch (IF) and load/store (D).
// Latency: req in IDLE at N -> mem_req at N+1; mem_ack at M -> *_valid at M+1 (>= 3 cycles/access).
// Backpressure: requesters hold req until *_valid, stall reports waiting; BUSY waits for mem_ack forever.
// Arbitration policy set by MEM_ARB_RR_EN (see arb_grant_sel).
// Ports: clk/reset (async active-low); if_* fetch port; d_* load/store port;
//        mem_* memory port; stall back to the CPU.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_valid,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  output logic                stall
);

  localparam int BE_W = DATA_W / 8;

  arb_state_e          state_q, state_d;
  req_id_e             grant_q, grant_d;
  req_id_e             ptr_q, ptr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

  logic    any_req;
  req_id_e sel;

  arb_grant_sel u_grant_sel (
    .if_req_i (if_req),
    .d_req_i  (d_req),
    .last_i   (ptr_q),
    .any_o    (any_req),
    .grant_o  (sel)
  );

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = BUSY;
          grant_d = sel;
          ptr_d   = sel;
          // Snapshot the winner so later requester-side changes cannot leak in.
          if (sel == REQ_D) begin
            addr_d  = d_addr;
            we_d    = d_we;
            wdata_d = d_wdata;
            be_d    = d_we ? d_be : BE_ALL[BE_W-1:0];
          end else begin
            addr_d  = if_addr;
            we_d    = 1'b0;
            wdata_d = '0;
            be_d    = BE_ALL[BE_W-1:0];
          end
        end
      end
      BUSY: begin
        if (mem_ack) begin
          state_d = RESP;
          if (grant_q == REQ_IF) begin
            if_rdata_d = mem_rdata;
          end else if (!we_q) begin
            d_rdata_d = mem_rdata;
          end
        end
      end
      RESP: begin
        // Requests are ignored here so the finishing requester can deassert.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      grant_q    <= REQ_IF;
      ptr_q      <= REQ_D;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      be_q       <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign mem_req   = (state_q == BUSY);
  assign mem_we    = mem_req & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;

  assign if_valid  = (state_q == RESP) && (grant_q == REQ_IF);
  assign d_valid   = (state_q == RESP) && (grant_q == REQ_D);
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

  assign stall     = (if_req & ~if_valid) | (d_req & ~d_valid);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter with a timeline-based reference model.
// Latency: checks every cycle against predicted grant/ack/valid cycle numbers.
// Backpressure: bench requesters hold req until valid; memory acks after 0..5 cycles.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_valid  (if_valid),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_be      (d_be),
    .d_rdata   (d_rdata),
    .d_valid   (d_valid),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .stall     (stall)
  );

  int total = 0;
  int bad   = 0;
  int t     = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h cycle=%0d", tag, got, exp, t);
    end
  endtask

  // Current transaction timeline: granted at g_c, ack at g_a, valid at g_a+1.
  bit          txn_on;
  int          g_c, g_a;
  bit          g_w;            // 1 = D won, 0 = IF won
  logic [31:0] g_addr, g_wdata, g_rdata;
  logic [3:0]  g_be;
  bit          g_we;
  int          free_at;        // first cycle the arbiter may accept again
`ifdef MEM_ARB_RR_EN
  bit          last_d;
`endif
  logic [31:0] exp_if_rd, exp_d_rd;

  // Requester state
  bit          if_out, d_out;
  bit          pend_if, pend_d;
  logic [31:0] pend_if_addr, pend_d_addr, pend_d_wdata;
  logic [3:0]  pend_d_be;
  bit          pend_d_we;
  int          p_if, p_d, p_drop;
  int          force_k;
  bit          force_rd_vld;
  logic [31:0] force_rd;

  task automatic model_reset();
    txn_on    = 0;
    if_out    = 0;
    d_out     = 0;
    pend_if   = 0;
    pend_d    = 0;
    exp_if_rd = '0;
    exp_d_rd  = '0;
    free_at   = t;
`ifdef MEM_ARB_RR_EN
    last_d    = 1;
`endif
  endtask

  task automatic drive_cycle();
    bit w;
    // Winner's inputs change after the grant; the latched copy must not move.
    if (txn_on && t > g_c) begin
      if (!g_w) begin
        if_addr = $urandom;
        if (if_req && $urandom_range(99) < p_drop) if_req = 0;
      end else begin
        d_addr  = $urandom;
        d_wdata = $urandom;
        d_be    = 4'($urandom);
        d_we    = 1'($urandom);
        if (d_req && $urandom_range(99) < p_drop) d_req = 0;
      end
    end
    if (!if_out) begin
      if_req  = 0;
      if_addr = $urandom;
      if (pend_if || $urandom_range(99) < p_if) begin
        if_out  = 1;
        if_req  = 1;
        if_addr = pend_if ? pend_if_addr : ($urandom & 32'hFFFF_FFFC);
        pend_if = 0;
      end
    end
    if (!d_out) begin
      d_req   = 0;
      d_addr  = $urandom;
      d_wdata = $urandom;
      d_be    = 4'($urandom);
      d_we    = 1'($urandom);
      if (pend_d || $urandom_range(99) < p_d) begin
        d_out = 1;
        d_req = 1;
        if (pend_d) begin
          d_we = pend_d_we; d_addr = pend_d_addr; d_wdata = pend_d_wdata; d_be = pend_d_be;
        end
        pend_d = 0;
      end
    end
    if (!txn_on && t >= free_at && (if_req || d_req)) begin
      if (if_req && d_req) begin
`ifdef MEM_ARB_RR_EN
        w = !last_d;
`else
        w = 1;
`endif
      end else begin
        w = d_req;
      end
`ifdef MEM_ARB_RR_EN
      last_d = w;
`endif
      g_w = w;
      g_c = t;
      g_a = t + 1 + ((force_k >= 0) ? force_k : int'($urandom_range(5)));
      if (w) begin
        g_addr = d_addr; g_we = d_we; g_wdata = d_wdata; g_be = d_we ? d_be : 4'hF;
      end else begin
        g_addr = if_addr; g_we = 0; g_wdata = '0; g_be = 4'hF;
      end
      g_rdata = force_rd_vld ? force_rd : $urandom;
      txn_on  = 1;
    end
    mem_ack   = txn_on && (t == g_a);
    mem_rdata = mem_ack ? g_rdata : $urandom;
  endtask

  task automatic check_cycle();
    bit e_req, e_ifv, e_dv;
    e_req = txn_on && (t > g_c) && (t <= g_a);
    e_ifv = txn_on && (t == g_a + 1) && !g_w;
    e_dv  = txn_on && (t == g_a + 1) && g_w;
    if (e_ifv) exp_if_rd = g_rdata;
    if (e_dv && !g_we) exp_d_rd = g_rdata;
    check_eq("mem_req", 64'(mem_req), 64'(e_req));
    if (e_req) begin
      check_eq("mem_addr", 64'(mem_addr), 64'(g_addr));
      check_eq("mem_we", 64'(mem_we), 64'(g_we));
      check_eq("mem_be", 64'(mem_be), 64'(g_be));
      if (g_we) check_eq("mem_wdata", 64'(mem_wdata), 64'(g_wdata));
    end
    check_eq("if_valid", 64'(if_valid), 64'(e_ifv));
    check_eq("d_valid", 64'(d_valid), 64'(e_dv));
    check_eq("if_rdata", 64'(if_rdata), 64'(exp_if_rd));
    check_eq("d_rdata", 64'(d_rdata), 64'(exp_d_rd));
    check_eq("stall", 64'(stall), 64'((if_req & ~e_ifv) | (d_req & ~e_dv)));
    if (e_ifv || e_dv) begin
      txn_on  = 0;
      free_at = t + 1;
      if (g_w) d_out = 0;
      else     if_out = 0;
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      t++;
      #1;
      drive_cycle();
      @(negedge clk);
      check_cycle();
    end
  endtask

  task automatic settle();
    int n = 0;
    while ((txn_on || if_out || d_out || pend_if || pend_d) && n < 100) begin
      run(1);
      n++;
    end
    if (n >= 100) check_eq("settle_timeout", 64'd1, 64'd0);
    run(1);
  endtask

  // Asserts reset mid-cycle and checks the asynchronous clear.
  task automatic do_reset();
    #2;
    reset   = 0;
    if_req  = 0;
    d_req   = 0;
    mem_ack = 0;
    #1;
    check_eq("rst_mem_req", 64'(mem_req), 64'd0);
    check_eq("rst_mem_we", 64'(mem_we), 64'd0);
    check_eq("rst_mem_addr", 64'(mem_addr), 64'd0);
    check_eq("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check_eq("rst_mem_be", 64'(mem_be), 64'd0);
    check_eq("rst_if_valid", 64'(if_valid), 64'd0);
    check_eq("rst_d_valid", 64'(d_valid), 64'd0);
    check_eq("rst_if_rdata", 64'(if_rdata), 64'd0);
    check_eq("rst_d_rdata", 64'(d_rdata), 64'd0);
    @(posedge clk); t++;
    @(posedge clk); t++;
    #1;
    reset = 1;
    model_reset();
  endtask

  task automatic issue_d(input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    pend_d = 1; pend_d_we = we; pend_d_addr = a; pend_d_wdata = wd; pend_d_be = be;
  endtask

  initial begin
    reset = 0; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0;
    d_wdata = '0; d_be = '0; mem_rdata = '0; mem_ack = 0;
    p_if = 0; p_d = 0; p_drop = 0; force_k = -1; force_rd_vld = 0; force_rd = '0;
    model_reset();
    do_reset();

    // Single fetch, ack one cycle after mem_req
    force_k = 1; force_rd_vld = 1; force_rd = 32'h0050_0093;
    pend_if = 1; pend_if_addr = 32'h0000_0010;
    settle();
    check_eq("fetch_rdata", 64'(if_rdata), 64'h0050_0093);

    // Load then store: store must leave d_rdata alone
    force_rd = 32'h1234_5678;
    issue_d(0, 32'h200, 32'h0, 4'h0);
    settle();
    force_rd = 32'hA5A5_A5A5;
    issue_d(1, 32'h100, 32'hDEAD_BEEF, 4'b0011);
    settle();
    check_eq("store_keeps_drdata", 64'(d_rdata), 64'h1234_5678);

    // Contention: both rise together
    force_rd_vld = 0; force_k = -1;
    pend_if = 1; pend_if_addr = 32'h40;
    issue_d(0, 32'h300, 32'h0, 4'h0);
    settle();

    // Slow memory with toggling fetch address after the grant
    force_k = 5;
    pend_if = 1; pend_if_addr = 32'h80;
    settle();

    // Random traffic, including early drops and back-to-back contention
    force_k = -1; p_if = 40; p_d = 40; p_drop = 10;
    run(2000);
    p_if = 100; p_d = 100; p_drop = 0;
    run(200);

    // Reset in the middle of a slow store
    p_if = 0; p_d = 0;
    settle();
    force_k = 5;
    issue_d(1, 32'h500, 32'hCAFE_F00D, 4'hC);
    for (int i = 0; i < 10 && !(txn_on && t > g_c); i++) run(1);
    check_eq("reach_busy", 64'(txn_on && t > g_c), 64'd1);
    do_reset();
    run(8);

    force_k = -1; p_if = 50; p_d = 50; p_drop = 5;
    run(500);
    p_if = 0; p_d = 0;
    settle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
